collision_manager: RTL and testbench

//  Sequences the game's response to the Detector's five per-obstacle collision flags.

---
 rtl/collision_manager_if.sv | 35 +++
 rtl/collision_manager.sv | 186 ++++++++++++++++++
 tb/tb_collision_manager.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/collision_manager_if.sv
`default_nettype none
// ============================================================================
//  Module      : collision_manager_if
//  Description : Bundles the frame/collision inputs and the crash/lives/
//                invulnerability outputs of collision_manager.
//                slave  : the collision manager (consumes flags, drives status)
//                master : the game side (drives flags, consumes status)
//  Ports       : frame_tick, game_active, iscollide[4:0]      (master -> slave)
//                crash, crash_idx[2:0], obstacle_clear[4:0],
//                lives[1:0], invuln, blink, game_over          (slave -> master)
//  Revision    : 1.0  initial release
// ============================================================================
interface collision_manager_if;
    logic       frame_tick;
    logic       game_active;
    logic [4:0] iscollide;
    logic       crash;
    logic [2:0] crash_idx;
    logic [4:0] obstacle_clear;
    logic [1:0] lives;
    logic       invuln;
    logic       blink;
    logic       game_over;

    modport master (
        output frame_tick, game_active, iscollide,
        input  crash, crash_idx, obstacle_clear, lives, invuln, blink, game_over
    );

    modport slave (
        input  frame_tick, game_active, iscollide,
        output crash, crash_idx, obstacle_clear, lives, invuln, blink, game_over
    );
endinterface
`default_nettype wire

// File: rtl/collision_manager.sv
`default_nettype none
// ============================================================================
//  Module      : collision_manager
//  Description : Confirms obstacle collisions over consecutive frame ticks,
//                selects the obstacle to remove, tracks lives, runs the
//                blinking invulnerability window and flags game over.
//  Ports       : clk    - system clock
//                reset  - synchronous active-high reset
//                bus    - collision_manager_if.slave (flags in, status out)
//  Revision    : 1.0  initial release
// ============================================================================
module collision_manager #(
    parameter int unsigned INIT_LIVES     = 3,
    parameter int unsigned CONFIRM_FRAMES = 2,
    parameter int unsigned INVULN_FRAMES  = 120,
    parameter int unsigned BLINK_FRAMES   = 8
) (
    input  wire logic           clk,
    input  wire logic           reset,
    collision_manager_if.slave  bus
);

    localparam logic [1:0] c_init_lives = 2'(INIT_LIVES);
    localparam logic [7:0] c_confirm    = 8'(CONFIRM_FRAMES);
    localparam logic [7:0] c_invuln     = 8'(INVULN_FRAMES);
    localparam logic [7:0] c_blink      = 8'(BLINK_FRAMES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_INVULN = 2'd2,
        S_OVER   = 2'd3
    } state_t;

    state_t     state_q;
    logic [7:0] confirm_q;
    logic [7:0] invuln_cnt_q;
    logic [7:0] blink_cnt_q;
    logic       crash_q;
    logic [2:0] crash_idx_q;
    logic [4:0] clear_q;
    logic [1:0] lives_q;
    logic       invuln_q;
    logic       blink_q;
    logic       game_over_q;

    logic [7:0] w_confirm_inc;
    logic [7:0] w_invuln_inc;
    logic [7:0] w_blink_inc;
    logic       w_any;
    logic       w_hit;
    logic [2:0] w_idx;

    // Saturating increments of the three frame counters.
    assign w_confirm_inc = (confirm_q    == 8'hFF) ? 8'hFF : confirm_q    + 8'd1;
    assign w_invuln_inc  = (invuln_cnt_q == 8'hFF) ? 8'hFF : invuln_cnt_q + 8'd1;
    assign w_blink_inc   = (blink_cnt_q  == 8'hFF) ? 8'hFF : blink_cnt_q  + 8'd1;

    assign w_any = |bus.iscollide;
    assign w_hit = w_any && (w_confirm_inc == c_confirm);

    // Lowest set flag wins: scan from the top so the lowest index is written last.
    always_comb begin
        w_idx = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (bus.iscollide[i]) begin
                w_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            confirm_q    <= 8'd0;
            invuln_cnt_q <= 8'd0;
            blink_cnt_q  <= 8'd0;
            crash_q      <= 1'b0;
            crash_idx_q  <= 3'd0;
            clear_q      <= 5'd0;
            lives_q      <= 2'd0;
            invuln_q     <= 1'b0;
            blink_q      <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            // crash and obstacle_clear are single-cycle pulses.
            crash_q <= 1'b0;
            clear_q <= 5'd0;
            case (state_q)
                S_IDLE: begin
                    game_over_q <= 1'b0;
                    invuln_q    <= 1'b0;
                    blink_q     <= 1'b0;
                    if (bus.game_active) begin
                        lives_q   <= c_init_lives;
                        confirm_q <= 8'd0;
                        state_q   <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Leaving the game outranks any hit confirmed on this tick.
                    if (!bus.game_active) begin
                        state_q      <= S_IDLE;
                        confirm_q    <= 8'd0;
                        invuln_cnt_q <= 8'd0;
                        blink_cnt_q  <= 8'd0;
                        invuln_q     <= 1'b0;
                        blink_q      <= 1'b0;
                    end else if (bus.frame_tick) begin
                        if (!w_any) begin
                            confirm_q <= 8'd0;
                        end else if (w_hit) begin
                            crash_q     <= 1'b1;
                            crash_idx_q <= w_idx;
                            clear_q     <= 5'(5'd1 << w_idx);
                            confirm_q   <= 8'd0;
                            // Last life: no invulnerability, straight to game over.
                            if (lives_q <= 2'd1) begin
                                lives_q     <= 2'd0;
                                game_over_q <= 1'b1;
                                state_q     <= S_OVER;
                            end else begin
                                lives_q      <= lives_q - 2'd1;
                                state_q      <= S_INVULN;
                                invuln_q     <= 1'b1;
                                blink_q      <= 1'b1;
                                invuln_cnt_q <= 8'd0;
                                blink_cnt_q  <= 8'd0;
                            end
                        end else begin
                            confirm_q <= w_confirm_inc;
                        end
                    end
                end
                S_INVULN: begin
                    if (!bus.game_active) begin
                        state_q      <= S_IDLE;
                        confirm_q    <= 8'd0;
                        invuln_cnt_q <= 8'd0;
                        blink_cnt_q  <= 8'd0;
                        invuln_q     <= 1'b0;
                        blink_q      <= 1'b0;
                    end else if (bus.frame_tick) begin
                        if (w_invuln_inc == c_invuln) begin
                            state_q      <= S_RUN;
                            invuln_q     <= 1'b0;
                            blink_q      <= 1'b0;
                            confirm_q    <= 8'd0;
                            invuln_cnt_q <= 8'd0;
                            blink_cnt_q  <= 8'd0;
                        end else begin
                            invuln_cnt_q <= w_invuln_inc;
                            if (w_blink_inc == c_blink) begin
                                blink_q     <= ~blink_q;
                                blink_cnt_q <= 8'd0;
                            end else begin
                                blink_cnt_q <= w_blink_inc;
                            end
                        end
                    end
                end
                S_OVER: begin
                    lives_q     <= 2'd0;
                    game_over_q <= 1'b1;
                    if (!bus.game_active) begin
                        state_q     <= S_IDLE;
                        game_over_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.crash          = crash_q;
    assign bus.crash_idx      = crash_idx_q;
    assign bus.obstacle_clear = clear_q;
    assign bus.lives          = lives_q;
    assign bus.invuln         = invuln_q;
    assign bus.blink          = blink_q;
    assign bus.game_over      = game_over_q;

endmodule
`default_nettype wire

// File: tb/tb_collision_manager.sv
`default_nettype none
// ============================================================================
//  Module      : tb_collision_manager
//  Description : Directed and randomized stimulus for collision_manager,
//                checked every cycle against a behavioural game model, plus
//                literal expectations for the documented scenarios.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_collision_manager;

    localparam int INIT = 3;
    localparam int CONF = 2;
    localparam int INV  = 120;
    localparam int BL   = 8;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_INV  = 2;
    localparam int M_OVER = 3;

    logic clk = 1'b0;
    logic reset;

    collision_manager_if cm_if ();

    collision_manager #(
        .INIT_LIVES     (INIT),
        .CONFIRM_FRAMES (CONF),
        .INVULN_FRAMES  (INV),
        .BLINK_FRAMES   (BL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (cm_if)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // State of play: mode, length of the current collision streak, and the
    // number of frame ticks elapsed since the last non-fatal hit.
    int         m_mode;
    int         m_streak;
    int         m_k;
    logic [1:0] m_lives;
    logic       m_crash;
    logic [2:0] m_idx;
    logic [4:0] m_clear;
    bit         m_valid = 0;

    always @(posedge clk) begin
        m_crash = 1'b0;
        m_clear = 5'd0;
        if (reset) begin
            m_valid  = 1;
            m_mode   = M_IDLE;
            m_streak = 0;
            m_k      = 0;
            m_lives  = 2'd0;
            m_idx    = 3'd0;
        end else if (m_valid) begin
            if (m_mode == M_IDLE) begin
                if (cm_if.game_active) begin
                    m_lives  = 2'(INIT);
                    m_streak = 0;
                    m_mode   = M_RUN;
                end
            end else if (m_mode == M_OVER) begin
                m_lives = 2'd0;
                if (!cm_if.game_active) m_mode = M_IDLE;
            end else if (!cm_if.game_active) begin
                m_mode   = M_IDLE;
                m_streak = 0;
                m_k      = 0;
            end else if (cm_if.frame_tick) begin
                if (m_mode == M_RUN) begin
                    if (cm_if.iscollide != 5'd0) begin
                        m_streak = (m_streak < 255) ? m_streak + 1 : 255;
                        if (m_streak == CONF) begin
                            for (int i = 4; i >= 0; i--)
                                if (cm_if.iscollide[i]) m_idx = 3'(i);
                            m_crash  = 1'b1;
                            m_clear  = 5'(1 << m_idx);
                            m_streak = 0;
                            if (m_lives == 2'd1) begin
                                m_lives = 2'd0;
                                m_mode  = M_OVER;
                            end else begin
                                m_lives = m_lives - 2'd1;
                                m_mode  = M_INV;
                                m_k     = 0;
                            end
                        end
                    end else begin
                        m_streak = 0;
                    end
                end else begin
                    m_k = m_k + 1;
                    if (m_k == INV) begin
                        m_mode   = M_RUN;
                        m_streak = 0;
                        m_k      = 0;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("crash",          cm_if.crash,          m_crash);
            chk("crash_idx",      cm_if.crash_idx,      m_idx);
            chk("obstacle_clear", cm_if.obstacle_clear, m_clear);
            chk("lives",          cm_if.lives,          m_lives);
            chk("invuln",         cm_if.invuln,         (m_mode == M_INV));
            chk("blink",          cm_if.blink,          (m_mode == M_INV) && (((m_k / BL) % 2) == 0));
            chk("game_over",      cm_if.game_over,      (m_mode == M_OVER));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One frame tick; returns just after the edge that sampled it.
    task automatic tick(input logic [4:0] c);
        cm_if.frame_tick = 1'b1;
        cm_if.iscollide  = c;
        cyc();
        cm_if.frame_tick = 1'b0;
    endtask

    initial begin
        reset             = 1'b1;
        cm_if.game_active = 1'b0;
        cm_if.frame_tick  = 1'b0;
        cm_if.iscollide   = 5'd0;
        repeat (3) cyc();
        reset = 1'b0;
        chk("rst_lives",     cm_if.lives,     2'd0);
        chk("rst_crash",     cm_if.crash,     1'b0);
        chk("rst_game_over", cm_if.game_over, 1'b0);
        chk("rst_invuln",    cm_if.invuln,    1'b0);

        // Game start
        cm_if.game_active = 1'b1;
        cyc();
        chk("start_lives", cm_if.lives, 2'd3);

        // Single-tick glitch does not confirm
        tick(5'b00100); cyc();
        tick(5'b00000);
        chk("glitch_crash", cm_if.crash, 1'b0);
        chk("glitch_lives", cm_if.lives, 2'd3);
        cyc();

        // Two-tick hit, lowest flag wins
        tick(5'b10110); cyc();
        tick(5'b10110);
        chk("hit1_crash", cm_if.crash,          1'b1);
        chk("hit1_idx",   cm_if.crash_idx,      3'd1);
        chk("hit1_clear", cm_if.obstacle_clear, 5'b00010);
        chk("hit1_lives", cm_if.lives,          2'd2);
        chk("hit1_inv",   cm_if.invuln,         1'b1);
        chk("hit1_blink", cm_if.blink,          1'b1);
        cyc();
        chk("hit1_pulse", cm_if.crash, 1'b0);

        // Invulnerability window with collisions held
        for (int i = 1; i <= INV; i++) begin
            tick(5'b11111);
            chk("inv_nocrash", cm_if.crash, 1'b0);
            if (i == 7)   chk("blink_t7",   cm_if.blink,  1'b1);
            if (i == 8)   chk("blink_t8",   cm_if.blink,  1'b0);
            if (i == 16)  chk("blink_t16",  cm_if.blink,  1'b1);
            if (i == 119) chk("inv_t119",   cm_if.invuln, 1'b1);
            if (i == 120) chk("inv_t120",   cm_if.invuln, 1'b0);
            cyc();
        end
        tick(5'b11111);
        chk("post_t1_crash", cm_if.crash, 1'b0);
        cyc();
        tick(5'b11111);
        chk("hit2_crash", cm_if.crash,     1'b1);
        chk("hit2_idx",   cm_if.crash_idx, 3'd0);
        chk("hit2_lives", cm_if.lives,     2'd1);
        cyc();

        // Ride out the second window, then the fatal hit
        for (int i = 1; i <= INV; i++) begin
            tick(5'b11000);
            cyc();
        end
        tick(5'b11000); cyc();
        tick(5'b11000);
        chk("hit3_crash", cm_if.crash,     1'b1);
        chk("hit3_idx",   cm_if.crash_idx, 3'd3);
        chk("hit3_lives", cm_if.lives,     2'd0);
        chk("hit3_over",  cm_if.game_over, 1'b1);
        chk("hit3_inv",   cm_if.invuln,    1'b0);
        cyc();
        cm_if.game_active = 1'b0;
        cyc();
        chk("idle_over",  cm_if.game_over, 1'b0);
        chk("idle_lives", cm_if.lives,     2'd0);

        // game_active dropped on the confirming tick
        cm_if.game_active = 1'b1;
        cyc();
        chk("restart_lives", cm_if.lives, 2'd3);
        tick(5'b00001); cyc();
        cm_if.game_active = 1'b0;
        tick(5'b00001);
        chk("drop_crash", cm_if.crash, 1'b0);
        chk("drop_lives", cm_if.lives, 2'd3);
        cyc();

        // Reset mid-invulnerability
        cm_if.game_active = 1'b1;
        cyc();
        tick(5'b01000); cyc();
        tick(5'b01000); cyc();
        tick(5'b00000); cyc();
        chk("pre_rst_inv", cm_if.invuln, 1'b1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("mid_rst_inv",   cm_if.invuln,         1'b0);
        chk("mid_rst_blink", cm_if.blink,          1'b0);
        chk("mid_rst_lives", cm_if.lives,          2'd0);
        chk("mid_rst_idx",   cm_if.crash_idx,      3'd0);
        chk("mid_rst_clear", cm_if.obstacle_clear, 5'd0);

        // Randomized play
        repeat (5000) begin
            reset             = ($urandom_range(0, 1499) == 0);
            cm_if.game_active = ($urandom_range(0, 799) != 0);
            cm_if.frame_tick  = ($urandom_range(0, 2) == 0);
            cm_if.iscollide   = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 31)) : 5'd0;
            cyc();
        end
        reset            = 1'b0;
        cm_if.frame_tick = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
